// File: rtl/ripemd160_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ripemd160_pkg: shared constants, FSM state and pad-mode types for the feeder.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ripemd160_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         DIGEST_W    = 160;
    localparam int         BLOCK_W     = BLOCK_BYTES * 8;

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_GUARD    = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_XTRA     = 3'd4,
        ST_WAIT_DIG = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PAD_NONE      = 2'd0,
        PAD_FINAL     = 2'd1,
        PAD_EXTRA80   = 2'd2,
        PAD_EXTRAZERO = 2'd3
    } pad_mode_t;

endpackage
`default_nettype wire

// File: rtl/ripemd160_pad_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ripemd160_pad_unit: combinational padding of a 512-bit little-endian block.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ripemd160_pad_unit
    import ripemd160_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [6:0]         n,
    input  logic [63:0]        bitlen,
    input  pad_mode_t          mode,
    output logic [BLOCK_W-1:0] blk_out
);

    int n_i;

    always_comb begin
        n_i     = int'(n);
        blk_out = blk_in;
        if (mode == PAD_FINAL) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (i == n_i) begin
                    blk_out[8*i +: 8] = PAD_BYTE;
                end else if (i > n_i) begin
                    blk_out[8*i +: 8] = 8'h00;
                end
            end
            // The length only fits when the marker landed before the length field.
            if (n_i < LEN_OFFSET) begin
                blk_out[8*LEN_OFFSET +: 64] = bitlen;
            end
        end else if (mode == PAD_EXTRA80 || mode == PAD_EXTRAZERO) begin
            blk_out                     = '0;
            blk_out[8*LEN_OFFSET +: 64] = bitlen;
            if (mode == PAD_EXTRA80) begin
                blk_out[7:0] = PAD_BYTE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ripemd160_msg_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ripemd160_msg_feeder: byte stream -> padded blocks -> RIPEMD-160 core; captures digest.
// Define RIPEMD_FEEDER_DBUF_EN for a second buffer that overlaps filling with issue.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ripemd160_msg_feeder
    import ripemd160_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                core_ready,
    output logic                core_init,
    output logic                core_next,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_digest_valid,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         idx;
    logic [6:0]         n_cnt;
    logic [LEN_W-1:0]   bitlen;
    logic [LEN_W-1:0]   bitlen_inc;
    logic [63:0]        len64;
    logic               extra_pend;
    logic               extra80;
    logic               final_blk;
    logic               first_pend;
    logic               init_q;
    logic               next_q;
    logic               busy_q;
    logic               digest_valid_q;
    logic [DIGEST_W-1:0] digest_q;
    logic               accept;
    logic               blk_done;
    logic               more;
    logic [BLOCK_W-1:0] cur_blk;
    logic [BLOCK_W-1:0] wr_blk;
    logic [BLOCK_W-1:0] pad_out;
    pad_mode_t          pad_mode;

    assign accept     = in_valid && in_ready;
    assign blk_done   = in_last || (idx == 6'd63);
    assign n_cnt      = {1'b0, idx} + 7'd1;
    assign bitlen_inc = bitlen + LEN_W'(8);

`ifdef RIPEMD_FEEDER_DBUF_EN
    logic [BLOCK_W-1:0] blk_q [2];
    logic [1:0]         full;
    logic               wr_sel;
    logic               rd_sel;

    assign cur_blk    = blk_q[wr_sel];
    assign core_block = blk_q[rd_sel];
    assign more       = full[~rd_sel];

    // Fill side and issue side each own one pointer; XTRA borrows the fill pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q[0] <= '0;
            blk_q[1] <= '0;
            full     <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            if (accept) begin
                blk_q[wr_sel] <= pad_out;
                if (blk_done) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
            end
            if (state == ST_XTRA) begin
                blk_q[wr_sel] <= pad_out;
                full[wr_sel]  <= 1'b1;
                wr_sel        <= ~wr_sel;
            end
            if (state == ST_WAIT_RDY && core_ready) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end
`else
    logic [BLOCK_W-1:0] blk_q;

    assign cur_blk    = blk_q;
    assign core_block = blk_q;
    assign more       = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q <= '0;
        end else if (accept || state == ST_XTRA) begin
            blk_q <= pad_out;
        end
    end
`endif

    always_comb begin
        wr_blk                   = cur_blk;
        wr_blk[{idx, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = (state == ST_XTRA) ? bitlen : bitlen_inc;
    end

    always_comb begin
        if (state == ST_XTRA) begin
            pad_mode = extra80 ? PAD_EXTRA80 : PAD_EXTRAZERO;
        end else if (in_last && idx != 6'd63) begin
            pad_mode = PAD_FINAL;
        end else begin
            pad_mode = PAD_NONE;
        end
    end

    ripemd160_pad_unit u_pad (
        .blk_in  (wr_blk),
        .n       (n_cnt),
        .bitlen  (len64),
        .mode    (pad_mode),
        .blk_out (pad_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
`ifdef RIPEMD_FEEDER_DBUF_EN
                if (full[rd_sel]) state_nxt = ST_ISSUE;
`else
                if (accept && blk_done) state_nxt = ST_ISSUE;
`endif
            end
            ST_ISSUE:    if (core_ready) state_nxt = ST_GUARD;
            ST_GUARD:    state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (core_ready) begin
                    if (more)            state_nxt = ST_FILL;
                    else if (extra_pend) state_nxt = ST_XTRA;
                    else if (final_blk)  state_nxt = ST_WAIT_DIG;
                    else                 state_nxt = ST_FILL;
                end
            end
            ST_XTRA:     state_nxt = ST_ISSUE;
            ST_WAIT_DIG: if (core_digest_valid) state_nxt = ST_FILL;
            default:     state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
`ifdef RIPEMD_FEEDER_DBUF_EN
        in_ready = !full[wr_sel] && !final_blk && !extra_pend;
`else
        in_ready = (state == ST_FILL);
`endif
        core_init    = init_q;
        core_next    = next_q;
        digest       = digest_q;
        digest_valid = digest_valid_q;
        busy         = busy_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx            <= '0;
            bitlen         <= '0;
            extra_pend     <= 1'b0;
            extra80        <= 1'b0;
            final_blk      <= 1'b0;
            first_pend     <= 1'b1;
            init_q         <= 1'b0;
            next_q         <= 1'b0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            if (accept) begin
                idx    <= idx + 6'd1;
                bitlen <= bitlen_inc;
                busy_q <= 1'b1;
                if (!busy_q) digest_valid_q <= 1'b0;
                if (in_last) begin
                    if (n_cnt < 7'(LEN_OFFSET)) begin
                        final_blk <= 1'b1;
                    end else begin
                        extra_pend <= 1'b1;
                        extra80    <= (idx == 6'd63);
                    end
                end
            end
            // Registered pulse lands in GUARD, where the core samples it.
            if (state == ST_ISSUE && core_ready) begin
                init_q     <= first_pend;
                next_q     <= !first_pend;
                first_pend <= 1'b0;
            end
            if (state == ST_XTRA) begin
                extra_pend <= 1'b0;
                final_blk  <= 1'b1;
            end
            if (state == ST_WAIT_DIG && core_digest_valid) begin
                digest_q       <= core_digest;
                digest_valid_q <= 1'b1;
                bitlen         <= '0;
                idx            <= '0;
                final_blk      <= 1'b0;
                busy_q         <= 1'b0;
                first_pend     <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ripemd160_msg_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ripemd160_msg_feeder: directed tests against a small RIPEMD-160 core model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ripemd160_msg_feeder;

    localparam logic [159:0] DIG = 160'hC0FFEE00_11223344_55667788_99AABBCC_DDEEFF01;

    logic         clk;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         core_ready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic [159:0] core_digest;
    logic         core_digest_valid;
    logic [159:0] digest;
    logic         digest_valid;
    logic         busy;

    int checks = 0;
    int passes = 0;

    logic [7:0]   msg [0:127];
    logic [511:0] blocks [0:3];
    int           nblk;
    int           n_init;
    int           n_next;
    int           lat_cnt;
    logic         model_ready;
    logic         hold_off;

    ripemd160_msg_feeder #(.LEN_W(64)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .core_ready        (core_ready),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_block        (core_block),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .digest            (digest),
        .digest_valid      (digest_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    assign core_ready  = model_ready && !hold_off;
    assign core_digest = DIG;

    // Core model: ready drops for a few cycles per block, digest valid afterwards.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_ready       <= 1'b1;
            lat_cnt           <= 0;
            core_digest_valid <= 1'b0;
            nblk              <= 0;
            n_init            <= 0;
            n_next            <= 0;
        end else if (core_init || core_next) begin
            model_ready        <= 1'b0;
            lat_cnt            <= 5;
            core_digest_valid  <= 1'b0;
            blocks[nblk % 4]   <= core_block;
            nblk               <= nblk + 1;
            if (core_init) n_init <= n_init + 1;
            if (core_next) n_next <= n_next + 1;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                model_ready       <= 1'b1;
                core_digest_valid <= 1'b1;
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        hold_off = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send(input int len, input bit with_last);
        int guard;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_data  = msg[i];
            in_valid = 1'b1;
            in_last  = with_last && (i == len - 1);
            guard    = 0;
            while (!in_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checks++;
                $display("FAIL send_timeout: byte %0d in_ready=%b required 1", i, in_ready);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_digest();
        int t = 0;
        while (!digest_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!digest_valid) begin
            checks++;
            $display("FAIL digest_timeout: digest_valid=%b required 1", digest_valid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_yang();
        logic [87:0] y;
        y = 88'h676E61592072657473614D;
        for (int i = 0; i < 11; i++) msg[i] = y[8*i +: 8];
    endtask

    task automatic load_count(input int len);
        for (int i = 0; i < len; i++) msg[i] = 8'(i + 1);
    endtask

    function automatic logic [511:0] yang_block();
        logic [511:0] e;
        e = '0;
        e[87:0]    = 88'h676E61592072657473614D;
        e[95:88]   = 8'h80;
        e[511:448] = 64'd88;
        return e;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (digest_valid !== 1'b0) $display("FAIL rst_digest_valid: got %b want 0", digest_valid); else passes++;
        checks++; if ({core_init, core_next} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {core_init, core_next}); else passes++;
        checks++; if (core_block !== 512'd0) $display("FAIL rst_block: got %h want 0", core_block); else passes++;
        checks++; if (digest !== 160'd0) $display("FAIL rst_digest: got %h want 0", digest); else passes++;
    endtask

    task automatic test_master_yang();
        do_reset();
        load_yang();
        send(11, 1'b1);
        checks++; if (busy !== 1'b1) $display("FAIL yang_busy: got %b want 1", busy); else passes++;
        checks++; if (digest_valid !== 1'b0) $display("FAIL yang_dv_early: got %b want 0", digest_valid); else passes++;
        wait_digest();
        checks++; if (blocks[0][87:0] !== 88'h676E61592072657473614D) $display("FAIL yang_data: got %h want 676e61592072657473614d", blocks[0][87:0]); else passes++;
        checks++; if (blocks[0][95:88] !== 8'h80) $display("FAIL yang_marker: got %h want 80", blocks[0][95:88]); else passes++;
        checks++; if (blocks[0][447:96] !== '0) $display("FAIL yang_zero: got %h want 0", blocks[0][447:96]); else passes++;
        checks++; if (blocks[0][511:448] !== 64'h58) $display("FAIL yang_len: got %h want 58", blocks[0][511:448]); else passes++;
        checks++; if (n_init !== 1 || n_next !== 0) $display("FAIL yang_pulses: got init=%0d next=%0d want 1/0", n_init, n_next); else passes++;
        checks++; if (digest !== DIG) $display("FAIL yang_digest: got %h want %h", digest, DIG); else passes++;
        checks++; if (digest_valid !== 1'b1) $display("FAIL yang_dv: got %b want 1", digest_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL yang_busy_end: got %b want 0", busy); else passes++;
    endtask

    task automatic test_len55();
        logic [511:0] e;
        do_reset();
        load_count(55);
        send(55, 1'b1);
        wait_digest();
        e = '0;
        for (int i = 0; i < 55; i++) e[8*i +: 8] = 8'(i + 1);
        e[447:440] = 8'h80;
        e[511:448] = 64'h1B8;
        checks++; if (blocks[0][447:440] !== 8'h80) $display("FAIL len55_marker: got %h want 80", blocks[0][447:440]); else passes++;
        checks++; if (blocks[0][511:448] !== 64'h1B8) $display("FAIL len55_len: got %h want 1b8", blocks[0][511:448]); else passes++;
        checks++; if (blocks[0] !== e) $display("FAIL len55_block: got %h want %h", blocks[0], e); else passes++;
        checks++; if (n_init !== 1 || n_next !== 0) $display("FAIL len55_pulses: got init=%0d next=%0d want 1/0", n_init, n_next); else passes++;
    endtask

    task automatic test_len56();
        logic [511:0] e;
        do_reset();
        load_count(56);
        send(56, 1'b1);
        wait_digest();
        e = '0;
        e[463:448] = 16'h01C0;
        checks++; if (blocks[0][455:448] !== 8'h80) $display("FAIL len56_marker: got %h want 80", blocks[0][455:448]); else passes++;
        checks++; if (blocks[0][511:456] !== '0) $display("FAIL len56_tail: got %h want 0", blocks[0][511:456]); else passes++;
        checks++; if (blocks[0][447:440] !== 8'h38) $display("FAIL len56_lastbyte: got %h want 38", blocks[0][447:440]); else passes++;
        checks++; if (blocks[1] !== e) $display("FAIL len56_extra: got %h want %h", blocks[1], e); else passes++;
        checks++; if (n_init !== 1 || n_next !== 1) $display("FAIL len56_pulses: got init=%0d next=%0d want 1/1", n_init, n_next); else passes++;
        checks++; if (digest !== DIG) $display("FAIL len56_digest: got %h want %h", digest, DIG); else passes++;
    endtask

    task automatic test_len64();
        logic [511:0] e;
        do_reset();
        load_count(64);
        send(64, 1'b1);
        wait_digest();
        e = '0;
        e[7:0]     = 8'h80;
        e[511:448] = 64'h200;
        checks++; if (blocks[0][511:504] !== 8'h40 || blocks[0][7:0] !== 8'h01) $display("FAIL len64_data: got b63=%h b0=%h want 40/01", blocks[0][511:504], blocks[0][7:0]); else passes++;
        checks++; if (blocks[1] !== e) $display("FAIL len64_extra: got %h want %h", blocks[1], e); else passes++;
        checks++; if (n_init !== 1 || n_next !== 1) $display("FAIL len64_pulses: got init=%0d next=%0d want 1/1", n_init, n_next); else passes++;
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        load_yang();
        hold_off = 1'b1;
        send(11, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (in_ready !== 1'b0 || core_init !== 1'b0 || core_next !== 1'b0 || core_block !== yang_block()) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad); else passes++;
        checks++; if (n_init !== 0) $display("FAIL stall_nopulse: got init=%0d want 0", n_init); else passes++;
        hold_off = 1'b0;
        wait_digest();
        checks++; if (n_init !== 1 || n_next !== 0) $display("FAIL stall_pulses: got init=%0d next=%0d want 1/0", n_init, n_next); else passes++;
        checks++; if (blocks[0] !== yang_block()) $display("FAIL stall_block: got %h want %h", blocks[0], yang_block()); else passes++;
    endtask

    task automatic test_async_reset();
        int t = 0;
        do_reset();
        load_count(100);
        send(64, 1'b0);
        while (n_init == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL arst_pre: got in_ready=%b busy=%b want 0/1", in_ready, busy); else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL arst_ctrl: got in_ready=%b busy=%b want 1/0", in_ready, busy); else passes++;
        checks++; if (core_block !== 512'd0 || digest_valid !== 1'b0) $display("FAIL arst_data: got block=%h dv=%b want 0/0", core_block, digest_valid); else passes++;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        load_yang();
        send(11, 1'b1);
        wait_digest();
        checks++; if (blocks[0] !== yang_block()) $display("FAIL arst_after_block: got %h want %h", blocks[0], yang_block()); else passes++;
        checks++; if (n_init !== 1 || n_next !== 0) $display("FAIL arst_after_pulses: got init=%0d next=%0d want 1/0", n_init, n_next); else passes++;
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        hold_off = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_master_yang();
        test_len55();
        test_len56();
        test_len64();
        test_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
